// File: rtl/mod6_seq_monitor_if.sv
// Signal bundle between a mod-6 count source and its sequence monitor.
// en qualifies cnt_in on every rising edge; there is no backpressure, the monitor always accepts.
interface mod6_seq_monitor_if #(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
);
    logic              en;
    logic              clr;
    logic [2:0]        cnt_in;
    logic              locked;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic              wrap_ovf;
    logic              err_skip;
    logic              err_illegal;
    logic [ERR_W-1:0]  err_count;
    logic [1:0]        state_dbg;

    modport master (
        output en, clr, cnt_in,
        input  locked, wrap_pulse, wrap_count, wrap_ovf,
        input  err_skip, err_illegal, err_count, state_dbg
    );

    modport slave (
        input  en, clr, cnt_in,
        output locked, wrap_pulse, wrap_count, wrap_ovf,
        output err_skip, err_illegal, err_count, state_dbg
    );
endinterface

// File: rtl/mod6_seq_monitor.sv
// Checks that an upstream mod-6 count follows 0..5..0, counts legal wraps
// and records sequence faults; state_dbg mirrors the FSM state register.
module mod6_seq_monitor #(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4,
    parameter int LOCK_N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    mod6_seq_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    localparam logic [2:0] LOCK_C = 3'(LOCK_N);

    state_t            state_q, state_d;
    logic [2:0]        prev_q, prev_d;
    logic              pv_q, pv_d;
    logic [2:0]        run_q, run_d;
    logic              locked_q;
    logic              wrap_pulse_q;
    logic [WRAP_W-1:0] wrap_count_q;
    logic              wrap_ovf_q;
    logic              err_skip_q;
    logic              err_illegal_q;
    logic [ERR_W-1:0]  err_count_q;

    logic       wrap_evt, skip_evt, ill_evt;
    logic [2:0] succ_prev, run_inc;
    logic       is_ill, is_hold, is_step;

    assign succ_prev = (prev_q == 3'd5) ? 3'd0 : prev_q + 3'd1;
    assign run_inc   = run_q + 3'd1;
    assign is_ill    = (bus.cnt_in >= 3'd6);
    assign is_hold   = pv_q && (bus.cnt_in == prev_q);
    assign is_step   = pv_q && (bus.cnt_in == succ_prev);

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        pv_d     = pv_q;
        run_d    = run_q;
        wrap_evt = 1'b0;
        skip_evt = 1'b0;
        ill_evt  = 1'b0;
        if (bus.en) begin
            if (state_q == ST_LOCKED) begin
                if (is_ill) begin
                    ill_evt = 1'b1;
                    pv_d    = 1'b0;
                    state_d = ST_FAULT;
                end else if (is_hold) begin
                    state_d = ST_LOCKED;
                end else if (is_step) begin
                    wrap_evt = (prev_q == 3'd5);
                    prev_d   = bus.cnt_in;
                end else begin
                    skip_evt = 1'b1;
                    prev_d   = bus.cnt_in;
                    state_d  = ST_FAULT;
                end
            end else begin
                // FAULT lasts one cycle and its sample follows the unlocked rules.
                state_d = ST_UNLOCKED;
                if (is_ill) begin
                    ill_evt = 1'b1;
                    run_d   = 3'd0;
                    pv_d    = 1'b0;
                end else if (is_hold) begin
                    run_d = run_q;
                end else if (is_step) begin
                    prev_d = bus.cnt_in;
                    if (run_inc == LOCK_C) begin
                        run_d   = 3'd0;
                        state_d = ST_LOCKED;
                    end else begin
                        run_d = run_inc;
                    end
                end else begin
                    run_d  = 3'd0;
                    prev_d = bus.cnt_in;
                    pv_d   = 1'b1;
                end
            end
        end else if (state_q == ST_FAULT) begin
            state_d = ST_UNLOCKED;
            run_d   = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_UNLOCKED;
            prev_q        <= 3'd0;
            pv_q          <= 1'b0;
            run_q         <= 3'd0;
            locked_q      <= 1'b0;
            wrap_pulse_q  <= 1'b0;
            wrap_count_q  <= '0;
            wrap_ovf_q    <= 1'b0;
            err_skip_q    <= 1'b0;
            err_illegal_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            pv_q         <= pv_d;
            run_q        <= run_d;
            locked_q     <= (state_d == ST_LOCKED);
            wrap_pulse_q <= wrap_evt;
            // clr discards any statistic event landing in the same cycle.
            if (bus.clr) begin
                wrap_count_q  <= '0;
                wrap_ovf_q    <= 1'b0;
                err_skip_q    <= 1'b0;
                err_illegal_q <= 1'b0;
                err_count_q   <= '0;
            end else begin
                if (wrap_evt) begin
                    wrap_count_q <= wrap_count_q + 1'b1;
                    if (&wrap_count_q) wrap_ovf_q <= 1'b1;
                end
                if (skip_evt) err_skip_q <= 1'b1;
                if (ill_evt) err_illegal_q <= 1'b1;
                if ((skip_evt || ill_evt) && !(&err_count_q)) err_count_q <= err_count_q + 1'b1;
            end
        end
    end

    assign bus.locked      = locked_q;
    assign bus.wrap_pulse  = wrap_pulse_q;
    assign bus.wrap_count  = wrap_count_q;
    assign bus.wrap_ovf    = wrap_ovf_q;
    assign bus.err_skip    = err_skip_q;
    assign bus.err_illegal = err_illegal_q;
    assign bus.err_count   = err_count_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_mod6_seq_monitor.sv
// Directed plus randomized check of mod6_seq_monitor against a sequence-rule model.
module tb_mod6_seq_monitor;
    localparam int WRAP_W = 4;
    localparam int ERR_W  = 4;
    localparam int LOCK_N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mod6_seq_monitor_if #(.WRAP_W(WRAP_W), .ERR_W(ERR_W)) bus ();

    mod6_seq_monitor #(.WRAP_W(WRAP_W), .ERR_W(ERR_W), .LOCK_N(LOCK_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: the monitor's observable rules with integer arithmetic.
    bit m_locked, m_fault, m_pv, m_wp, m_ovf, m_skip, m_ill;
    int m_prev, m_run, m_wc, m_ec;

    task automatic model_step(input bit r_n, input bit e, input bit c, input int v);
        bit wrap_ev, skip_ev, ill_ev, was_fault;
        wrap_ev = 0; skip_ev = 0; ill_ev = 0;
        if (!r_n) begin
            m_locked = 0; m_fault = 0; m_pv = 0; m_wp = 0; m_ovf = 0; m_skip = 0; m_ill = 0;
            m_prev = 0; m_run = 0; m_wc = 0; m_ec = 0;
            return;
        end
        was_fault = m_fault;
        m_fault = 0;
        if (e) begin
            if (v >= 6) begin
                ill_ev = 1;
                m_pv = 0;
                if (m_locked) begin m_locked = 0; m_fault = 1; end
                else m_run = 0;
            end else if (m_pv && v == m_prev) begin
                // hold: nothing moves
            end else if (m_pv && v == (m_prev + 1) % 6) begin
                if (m_locked) begin
                    if (m_prev == 5) wrap_ev = 1;
                end else begin
                    m_run++;
                    if (m_run == LOCK_N) begin m_locked = 1; m_run = 0; end
                end
                m_prev = v;
            end else begin
                if (m_locked) begin
                    skip_ev = 1; m_locked = 0; m_fault = 1;
                end else begin
                    m_run = 0; m_pv = 1;
                end
                m_prev = v;
            end
        end else if (was_fault) begin
            m_run = 0;
        end
        m_wp = wrap_ev;
        if (c) begin
            m_wc = 0; m_ovf = 0; m_skip = 0; m_ill = 0; m_ec = 0;
        end else begin
            if (wrap_ev) begin
                m_wc = (m_wc + 1) % (1 << WRAP_W);
                if (m_wc == 0) m_ovf = 1;
            end
            if (skip_ev) m_skip = 1;
            if (ill_ev) m_ill = 1;
            if ((skip_ev || ill_ev) && m_ec < (1 << ERR_W) - 1) m_ec++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("locked", 32'(bus.locked), 32'(m_locked));
        check("wrap_pulse", 32'(bus.wrap_pulse), 32'(m_wp));
        check("wrap_count", 32'(bus.wrap_count), 32'(m_wc));
        check("wrap_ovf", 32'(bus.wrap_ovf), 32'(m_ovf));
        check("err_skip", 32'(bus.err_skip), 32'(m_skip));
        check("err_illegal", 32'(bus.err_illegal), 32'(m_ill));
        check("err_count", 32'(bus.err_count), 32'(m_ec));
    endtask

    // Drive on the falling edge like the upstream counter, sample 1 ns after the rising edge.
    task automatic step(input bit r_n, input bit e, input bit c, input int v);
        @(negedge clk);
        rst_n      = r_n;
        bus.en     = e;
        bus.clr    = c;
        bus.cnt_in = 3'(v);
        @(posedge clk);
        model_step(r_n, e, c, v);
        #1;
        check_all();
    endtask

    task automatic drive(input int v);
        step(1'b1, 1'b1, 1'b0, v);
    endtask

    initial begin
        int last_v;
        bus.en = 1'b0; bus.clr = 1'b0; bus.cnt_in = 3'd0;
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 3);
        check("reset_locked", 32'(bus.locked), 32'd0);
        check("reset_err_count", 32'(bus.err_count), 32'd0);

        // Lock after 0,1,2,3
        drive(0); drive(1); drive(2);
        check("pre_lock", 32'(bus.locked), 32'd0);
        drive(3);
        check("lock", 32'(bus.locked), 32'd1);
        check("lock_wrap_count", 32'(bus.wrap_count), 32'd0);

        // One wrap, then 16 more so the 4-bit counter rolls over
        drive(4); drive(5);
        check("pre_wrap_pulse", 32'(bus.wrap_pulse), 32'd0);
        drive(0);
        check("wrap_pulse", 32'(bus.wrap_pulse), 32'd1);
        check("wrap_count_1", 32'(bus.wrap_count), 32'd1);
        drive(1);
        check("wrap_pulse_once", 32'(bus.wrap_pulse), 32'd0);
        for (int i = 0; i < 16; i++) begin
            drive(2); drive(3); drive(4); drive(5); drive(0); drive(1);
        end
        check("wrap_count_17", 32'(bus.wrap_count), 32'd1);
        check("wrap_ovf", 32'(bus.wrap_ovf), 32'd1);

        // Skip while locked at 3, then relock through 5->0,0->1,1->2
        step(1'b1, 1'b0, 1'b1, 0);
        drive(2); drive(3); drive(5);
        check("skip_flag", 32'(bus.err_skip), 32'd1);
        check("skip_count", 32'(bus.err_count), 32'd1);
        check("skip_fault_unlocked", 32'(bus.locked), 32'd0);
        drive(0);
        check("no_pulse_unlocked", 32'(bus.wrap_pulse), 32'd0);
        drive(1);
        check("still_unlocked", 32'(bus.locked), 32'd0);
        drive(2);
        check("relock", 32'(bus.locked), 32'd1);

        // Illegal while unlocked, hold, and en=0 masking
        step(1'b0, 1'b0, 1'b0, 0);
        drive(7);
        check("illegal_flag", 32'(bus.err_illegal), 32'd1);
        check("illegal_count", 32'(bus.err_count), 32'd1);
        check("illegal_no_skip", 32'(bus.err_skip), 32'd0);
        drive(2); drive(2); drive(2);
        check("hold_count", 32'(bus.err_count), 32'd1);
        step(1'b1, 1'b0, 1'b0, 6);
        check("en0_count", 32'(bus.err_count), 32'd1);

        // Saturation, then clr colliding with an error that forces FAULT
        for (int i = 0; i < 20; i++) drive($urandom_range(6, 7));
        check("saturate", 32'(bus.err_count), 32'd15);
        drive(0); drive(1); drive(2); drive(3);
        step(1'b1, 1'b1, 1'b1, 7);
        check("clr_err_count", 32'(bus.err_count), 32'd0);
        check("clr_illegal", 32'(bus.err_illegal), 32'd0);
        check("clr_fault", 32'(bus.locked), 32'd0);
        drive(0);

        // Reset mid-operation with wrap_count at 5
        drive(1); drive(2); drive(3);
        for (int i = 0; i < 5; i++) begin
            drive(4); drive(5); drive(0); drive(1); drive(2); drive(3);
        end
        check("wraps_5", 32'(bus.wrap_count), 32'd5);
        step(1'b0, 1'b1, 1'b0, 4);
        check("midreset_wrap_count", 32'(bus.wrap_count), 32'd0);
        check("midreset_locked", 32'(bus.locked), 32'd0);
        drive(0); drive(1); drive(2);
        check("fresh_unlocked", 32'(bus.locked), 32'd0);
        drive(3);
        check("fresh_relock", 32'(bus.locked), 32'd1);

        // Randomized traffic: mostly legal progress with holds, jumps, illegals, clr, reset
        last_v = 3;
        for (int i = 0; i < 600; i++) begin
            int r, v;
            bit e, c, rn;
            r = $urandom_range(0, 99);
            if (r < 70)      v = (last_v + 1) % 6;
            else if (r < 82) v = last_v;
            else if (r < 93) v = $urandom_range(0, 5);
            else             v = $urandom_range(6, 7);
            e  = ($urandom_range(0, 9) != 0);
            c  = ($urandom_range(0, 29) == 0);
            rn = ($urandom_range(0, 79) != 0);
            step(rn, e, c, v);
            if (v < 6) last_v = v;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mod6_seq_monitor.md
Name: mod6_seq_monitor

Overview:
- Downstream consumer of the 3-bit mod-6 count. Samples the count every rising clk edge and checks that it follows the legal sequence 0-1-2-3-4-5-0.
- Counts completed wraps (5->0) and reports sequence faults (skips, illegal codes 6/7) with sticky flags and a saturating error counter.
- Feeds the status/debug register bank and any divide-by-6 consumers that need a wrap strobe.

Parameters:
- WRAP_W, 8, width of wrap_count.
- ERR_W, 4, width of err_count (saturating).
- LOCK_N, 3, consecutive legal increments required to declare lock (range 1..7).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- en  in  1  sample enable; when 0 cnt_in is ignored and all state holds.
- clr  in  1  synchronous clear of statistics (wrap_count, err_count, sticky flags); FSM unaffected.
- cnt_in  in  3  mod-6 count from the upstream counter (stable at rising clk; upstream updates on falling edge).
- locked  out  1  1 while FSM is in LOCKED.
- wrap_pulse  out  1  one-cycle strobe per legal 5->0 transition while LOCKED.
- wrap_count  out  WRAP_W  number of legal wraps, modulo 2^WRAP_W.
- wrap_ovf  out  1  sticky; set when wrap_count rolls over from all-ones to 0.
- err_skip  out  1  sticky; set on an out-of-sequence legal value while LOCKED.
- err_illegal  out  1  sticky; set on cnt_in = 6 or 7 in any state.
- err_count  out  ERR_W  total faults, saturates at all-ones.

Behaviour:
- All outputs registered. Sample at edge N is reflected at outputs after edge N, so latency is 1 cycle.
- Reset (rst_n=0 at an edge) has priority over everything, including mid-operation:
  - FSM to UNLOCKED; prev_valid=0; run counter=0.
  - All outputs 0.
- Internal state:
  - prev[2:0] is the last legal sampled value; prev_valid marks it as meaningful.
  - succ(x) = (x==5) ? 0 : x+1.
- en=0: no register changes except clr/reset handling; wrap_pulse=0.
- Classification of a sample v when en=1:
  - ILLEGAL: v>=6.
  - HOLD: prev_valid and v==prev.
  - STEP: prev_valid and v==succ(prev).
  - JUMP: any other legal v.
- FSM states: UNLOCKED, LOCKED, FAULT.
- UNLOCKED:
  - STEP: run++. When run reaches LOCK_N, go to LOCKED and set run=0.
  - JUMP, or first sample (prev_valid=0): run=0, prev=v, prev_valid=1.
  - HOLD: no change.
  - ILLEGAL: err_illegal=1, err_count+1, run=0, prev_valid=0. No skip error is reported in this state.
  - No wrap_pulse is issued in this state. A 5->0 step still counts toward run.
- LOCKED:
  - HOLD: nothing.
  - STEP: prev=v. If prev==5 and v==0: wrap_pulse=1 next cycle and wrap_count+1; on rollover, set wrap_ovf.
  - JUMP: err_skip=1, err_count+1, go to FAULT, prev=v.
  - ILLEGAL: err_illegal=1, err_count+1, go to FAULT, prev_valid=0.
- FAULT:
  - Lasts exactly one cycle; locked=0.
  - Next edge goes to UNLOCKED with run=0, regardless of en.
  - The sample taken in the FAULT cycle is processed with UNLOCKED rules.
- err_count holds at 2^ERR_W-1 and never wraps.
- clr=1:
  - wrap_count, err_count, wrap_ovf, err_skip and err_illegal are set to 0.
  - clr wins over a same-cycle increment or sticky set; that event is not recorded.
  - wrap_pulse and FSM transitions still occur normally.
- Only one error class is flagged per sample (the ILLEGAL/JUMP classification is exclusive), and err_count increments by at most 1 per cycle.

Test Plan:
- Lock: reset, en=1, drive 0,1,2,3 on successive cycles -> locked=1 the cycle after 3 is sampled; wrap_count=0; no errors.
- Wrap: from lock, continue 4,5,0,1 -> exactly one wrap_pulse (cycle after 0 sampled), wrap_count=1. Repeat 0..5 cycle 16 times with WRAP_W=4 -> wrap_count=1 (after 17 wraps), wrap_ovf=1.
- Skip: locked at prev=3, drive 5 -> err_skip=1, err_count=1, locked=0 for FAULT cycle; then drive 0,1,2 -> relock after 3 steps (5->0 counted), no wrap_pulse during UNLOCKED.
- Illegal/hold/en: drive 7 while UNLOCKED -> err_illegal=1, err_count=1, err_skip=0. Repeated 2,2,2 -> no change. en=0 with cnt_in=6 -> no flag.
- Saturation and clr: inject 20 illegal samples with ERR_W=4 -> err_count=15. Assert clr in the same cycle as an error -> all stats 0, FSM still enters FAULT.
- Reset mid-operation: rst_n=0 for one edge while LOCKED with wrap_count=5 -> all outputs 0 next cycle; relock needs LOCK_N fresh steps.
